// File: rtl/port_tx_engine.sv
// -----------------------------------------------------------------------------
// port_tx_engine
//
// Egress engine of one switch output port. It sits on the read side of the
// port's output FIFO. It pops complete packets one byte at a time and presents
// them on a byte-wide valid/ready interface with start/end-of-packet markers.
// A packet whose destination address (DA) differs from PORT_ID is still popped
// byte by byte, but it is never shown on the port.
//
// Packet layout in the FIFO: DA, SA, LEN, then LEN payload bytes (LEN may be 0).
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   fifo_empty    output FIFO empty flag
//   fifo_data     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    FIFO pop strobe, one cycle per byte
//   port_valid    port_data holds a valid byte
//   port_ready    downstream accepts the byte this cycle
//   port_data     transmitted byte
//   port_sop      current byte is the DA byte
//   port_eop      current byte is the last byte of the packet
//   busy          a packet is in progress
//   tx_pkt_cnt    packets fully transmitted (wraps)
//   drop_pkt_cnt  packets drained without transmission (wraps)
// -----------------------------------------------------------------------------
module port_tx_engine #(
  parameter int                 W_WIDTH   = 8,
  parameter logic [W_WIDTH-1:0] PORT_ID   = '0,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [W_WIDTH-1:0]   fifo_data,
  output logic                 fifo_rd_en,
  output logic                 port_valid,
  input  logic                 port_ready,
  output logic [W_WIDTH-1:0]   port_data,
  output logic                 port_sop,
  output logic                 port_eop,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_pkt_cnt
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE = 3'd0;  // waiting for a packet
  localparam logic [2:0] ST_RD   = 3'd1;  // pop one byte (stalls on underrun)
  localparam logic [2:0] ST_CAP  = 3'd2;  // capture popped byte
  localparam logic [2:0] ST_SEND = 3'd3;  // hold byte until handshake
  localparam logic [2:0] ST_NEXT = 3'd4;  // advance or finish the packet

  // Byte index positions inside a packet.
  localparam logic [8:0] IDX_DA  = 9'd0;
  localparam logic [8:0] IDX_LEN = 9'd2;

  logic [2:0]         state;
  // Nine bits so the last byte of a LEN=255 packet (index 257) is reachable.
  logic [8:0]         byte_idx;
  logic [W_WIDTH-1:0] remaining;   // LEN field of the packet in progress
  logic               drop;        // packet in progress is being discarded
  logic               last;        // byte just captured is the final one

  // Decisions taken on the byte being captured this cycle. At index 0 the drop
  // verdict and at index 2 the length are not yet registered, so both are
  // derived from fifo_data directly.
  logic               cap_drop;
  logic               cap_last;
  logic [8:0]         last_idx;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cap_drop = drop;
    cap_last = 1'b0;
    last_idx = {{(9 - W_WIDTH){1'b0}}, remaining} + IDX_LEN;

    if (byte_idx == IDX_DA) begin
      cap_drop = (fifo_data != PORT_ID);
    end

    if (byte_idx == IDX_LEN) begin
      cap_last = (fifo_data == '0);
    end else if (byte_idx > IDX_LEN) begin
      cap_last = (byte_idx == last_idx);
    end
  end

  // Pop only from RD, and never while the FIFO reports empty. This is decoded
  // from registered state, so it is low throughout reset.
  assign fifo_rd_en = (state == ST_RD) && !fifo_empty;
  assign busy       = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      remaining    <= '0;
      drop         <= 1'b0;
      last         <= 1'b0;
      port_valid   <= 1'b0;
      port_data    <= '0;
      port_sop     <= 1'b0;
      port_eop     <= 1'b0;
      tx_pkt_cnt   <= '0;
      drop_pkt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_RD;
          end
        end

        ST_RD: begin
          // An empty FIFO here is a mid-packet underrun. Wait indefinitely.
          if (!fifo_empty) begin
            state <= ST_CAP;
          end
        end

        ST_CAP: begin
          port_data <= fifo_data;
          drop      <= cap_drop;
          last      <= cap_last;
          if (byte_idx == IDX_LEN) begin
            remaining <= fifo_data;
          end
          if (!cap_drop) begin
            port_valid <= 1'b1;
            port_sop   <= (byte_idx == IDX_DA);
            port_eop   <= cap_last;
            state      <= ST_SEND;
          end else begin
            state      <= ST_NEXT;
          end
        end

        ST_SEND: begin
          // port_valid is always set in this state, so port_ready alone
          // completes the handshake.
          if (port_ready) begin
            port_valid <= 1'b0;
            port_sop   <= 1'b0;
            port_eop   <= 1'b0;
            state      <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (last) begin
            byte_idx <= '0;
            last     <= 1'b0;
            if (drop) begin
              drop_pkt_cnt <= drop_pkt_cnt + 1'b1;
            end else begin
              tx_pkt_cnt   <= tx_pkt_cnt + 1'b1;
            end
            drop  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= ST_RD;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_port_tx_engine
//
// Scoreboard bench for port_tx_engine (PORT_ID = 3). A behavioural FIFO feeds
// the DUT. Each packet pushed into the FIFO also queues the bytes the port is
// expected to show. A separate monitor pops the expectations on every port
// handshake and also watches for stall stability and illegal pops.
// -----------------------------------------------------------------------------
module tb_port_tx_engine;

  localparam int         W   = 8;
  localparam int         CW  = 16;
  localparam logic [7:0] PID = 8'h03;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data  = '0;
  logic          fifo_rd_en;
  logic          port_valid;
  logic          port_ready = 1'b1;
  logic [W-1:0]  port_data;
  logic          port_sop;
  logic          port_eop;
  logic          busy;
  logic [CW-1:0] tx_pkt_cnt;
  logic [CW-1:0] drop_pkt_cnt;

  port_tx_engine #(
    .W_WIDTH  (W),
    .PORT_ID  (PID),
    .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .port_valid  (port_valid),
    .port_ready  (port_ready),
    .port_data   (port_data),
    .port_sop    (port_sop),
    .port_eop    (port_eop),
    .busy        (busy),
    .tx_pkt_cnt  (tx_pkt_cnt),
    .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];   // FIFO contents
  logic [7:0] held[$];     // bytes withheld to create an underrun
  logic [7:0] pkt[$];      // packet under construction
  logic [9:0] exp_q[$];    // expected {sop, eop, data} per handshake
  int         pops    = 0;
  int         hs      = 0;
  int         exp_tx  = 0;
  int         exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Behavioural FIFO: data appears the cycle after the pop. The empty flag is
  // refreshed just after each edge so the DUT sees it stable.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      pops++;
    end
  end

  always @(posedge clk) begin
    #1;
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: inputs change at posedge+2, so the negedge sample shows the value
  // the DUT sees at the following posedge.
  logic        stall_v = 1'b0;
  logic [10:0] stall_val = '0;
  logic [9:0]  exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v)
        check("stall_hold", {port_valid, port_sop, port_eop, port_data}, stall_val);
      if (fifo_rd_en) begin
        check("rd_en_while_empty", fifo_empty, 1'b0);
        check("rd_en_while_valid", port_valid, 1'b0);
      end
      if (port_valid && port_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h sop=%0b eop=%0b want none",
                   port_data, port_sop, port_eop);
        end else begin
          exp_e = exp_q.pop_front();
          check("port_byte", {port_sop, port_eop, port_data}, exp_e);
        end
        stall_v = 1'b0;
      end else if (port_valid) begin
        stall_v   = 1'b1;
        stall_val = {1'b1, port_sop, port_eop, port_data};
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Load pkt into the FIFO, keeping the last 'hold' bytes back, and queue the
  // expected port bytes unless the DA does not match this port.
  task automatic push_pkt(input int hold);
    logic drp;
    logic s;
    logic e;
    int   last;
    drp  = (pkt[0] != PID);
    last = pkt.size() - 1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i < pkt.size() - hold) fifo_q.push_back(pkt[i]);
      else                       held.push_back(pkt[i]);
      if (!drp) begin
        s = (i == 0);
        e = (i == last);
        exp_q.push_back({s, e, pkt[i]});
      end
    end
    if (drp) exp_drop++;
    else     exp_tx++;
    pkt.delete();
  endtask

  task automatic release_held();
    while (held.size() > 0) fifo_q.push_back(held.pop_front());
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, (n < budget), 1'b1);
  endtask

  task automatic wait_hs(input string name, input int target);
    int n;
    n = 0;
    while (hs < target && n < 200) begin
      tick();
      n++;
    end
    check({name, "_hs_timeout"}, (n < 200), 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!port_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_valid_timeout"}, (n < 50), 1'b1);
  endtask

  task automatic check_counters(input string name);
    check({name, "_tx_cnt"},   tx_pkt_cnt,   exp_tx);
    check({name, "_drop_cnt"}, drop_pkt_cnt, exp_drop);
    check({name, "_busy"},     busy,         1'b0);
  endtask

  int hs0;

  initial begin
    // Reset state.
    tick(3);
    check("rst_outputs", {fifo_rd_en, port_valid, port_sop, port_eop, busy}, 5'b0);
    check("rst_data",    port_data,    8'h00);
    check("rst_tx",      tx_pkt_cnt,   16'h0);
    check("rst_drop",    drop_pkt_cnt, 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Matching packet, with first-byte latency.
    pops = 0;
    pkt  = '{8'h03, 8'h07, 8'h02, 8'hAA, 8'hBB};
    push_pkt(0);
    tick();
    check("lat_rd_early",  fifo_rd_en, 1'b0);
    tick();
    check("lat_rd",        fifo_rd_en, 1'b1);
    tick();
    check("lat_valid_early", port_valid, 1'b0);
    tick();
    check("lat_valid",     port_valid, 1'b1);
    wait_idle("match", 200);
    check("match_pops", pops, 5);
    check_counters("match");

    // LEN = 0 packet, then a packet for another port.
    pops = 0;
    pkt  = '{8'h03, 8'h05, 8'h00};
    push_pkt(0);
    wait_idle("len0", 200);
    check("len0_pops", pops, 3);
    check_counters("len0");
    pops = 0;
    pkt  = '{8'h09, 8'h05, 8'h01, 8'hCC};
    push_pkt(0);
    wait_idle("drop", 200);
    check("drop_pops", pops, 4);
    check_counters("drop");

    // Backpressure on the SA byte for 10 cycles.
    pops = 0;
    hs0  = hs;
    pkt  = '{8'h03, 8'h11, 8'h01, 8'h22};
    push_pkt(0);
    wait_hs("bp", hs0 + 1);
    port_ready = 1'b0;
    wait_valid("bp");
    check("bp_sa_data", {port_sop, port_eop, port_data}, {2'b00, 8'h11});
    tick(10);
    check("bp_still_valid", port_valid, 1'b1);
    check("bp_pops", pops, 2);
    port_ready = 1'b1;
    wait_idle("bp", 200);
    check_counters("bp");

    // Underrun after the LEN byte.
    pkt = '{8'h03, 8'h07, 8'h01, 8'h5A};
    push_pkt(1);
    tick(20);
    check("ur_busy",  busy,       1'b1);
    check("ur_rd_en", fifo_rd_en, 1'b0);
    check("ur_valid", port_valid, 1'b0);
    release_held();
    wait_idle("ur", 200);
    check_counters("ur");

    // Reset while payload byte 2 of 4 waits in SEND.
    hs0 = hs;
    pkt = '{8'h03, 8'h01, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    push_pkt(0);
    wait_hs("mrst", hs0 + 4);
    port_ready = 1'b0;
    wait_valid("mrst");
    check("mrst_p2", port_data, 8'h20);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_outputs", {fifo_rd_en, port_valid, port_sop, port_eop, busy}, 5'b0);
    check("mrst_data",    port_data,    8'h00);
    check("mrst_tx",      tx_pkt_cnt,   16'h0);
    check("mrst_drop",    drop_pkt_cnt, 16'h0);
    fifo_q.delete();
    exp_q.delete();
    exp_tx   = 0;
    exp_drop = 0;
    tick(2);
    rst_n      = 1'b1;
    port_ready = 1'b1;
    tick(3);
    check_counters("mrst_after");

    // Maximum length: LEN = 255, 258 bytes.
    pops = 0;
    hs0  = hs;
    pkt.push_back(8'h03);
    pkt.push_back(8'h02);
    pkt.push_back(8'hFF);
    for (int i = 0; i < 255; i++) pkt.push_back(8'(i));
    push_pkt(0);
    wait_idle("maxlen", 2000);
    check("maxlen_pops", pops, 258);
    check("maxlen_hs",   hs - hs0, 258);
    check_counters("maxlen");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
